// File: rtl/csr_machine_file.sv
// Machine-mode CSR register file with trap-entry / mret sequencing and 64-bit cycle/instret counters.
// Reads are combinational with no write bypass; writes, traps and returns take effect at the clock edge.
module csr_machine_file #(
  parameter logic [31:0] MTVEC_RESET   = 32'h0000_0000,
  parameter int          COUNTER_WIDTH = 64
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        readEnable,
  input  logic [11:0] readAddr,
  output logic [31:0] readValue,
  output logic        readIllegal,
  input  logic        writeEnable,
  input  logic [11:0] writeAddr,
  input  logic [31:0] writeValue,
  input  logic        trapValid,
  input  logic        trapInterrupt,
  input  logic [4:0]  trapCause,
  input  logic [31:0] trapValue,
  input  logic [31:0] trapPc,
  input  logic        trapReturn,
  input  logic        retire,
  output logic [31:0] nextPc,
  output logic        nextPcValid,
  output logic [1:0]  privilege,
  output logic [31:0] mstatus
);

  typedef enum logic [1:0] {
    PRIV_U = 2'd0,
    PRIV_S = 2'd1,
    PRIV_M = 2'd3
  } privT;

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MTVAL     = 12'h343;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
  localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
  localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
  localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;

  privT                     privReg;
  privT                     mpp;
  logic                     mie;
  logic                     mpie;
  logic [31:0]              mtvec;
  logic [31:0]              mscratch;
  logic [31:0]              mepc;
  logic [31:0]              mcause;
  logic [31:0]              mtval;
  logic [COUNTER_WIDTH-1:0] mcycle;
  logic [COUNTER_WIDTH-1:0] minstret;

  function automatic logic csrMapped(input logic [11:0] addr);
    case (addr)
      ADDR_MSTATUS, ADDR_MTVEC, ADDR_MSCRATCH, ADDR_MEPC, ADDR_MCAUSE, ADDR_MTVAL,
      ADDR_MCYCLE, ADDR_MCYCLEH, ADDR_MINSTRET, ADDR_MINSTRETH,
      ADDR_CYCLE, ADDR_CYCLEH, ADDR_INSTRET, ADDR_INSTRETH: csrMapped = 1'b1;
      default:                                              csrMapped = 1'b0;
    endcase
  endfunction

  assign privilege = privReg;
  assign mstatus   = {19'b0, mpp, 3'b0, mpie, 3'b0, mie, 3'b0};

  // ---------------------------------------------------------------------------
  // Combinational read port
  // ---------------------------------------------------------------------------
  logic [31:0] readData;
  logic        readMapped;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    readData   = '0;
    readMapped = csrMapped(readAddr);
    case (readAddr)
      ADDR_MSTATUS:                  readData = mstatus;
      ADDR_MTVEC:                    readData = mtvec;
      ADDR_MSCRATCH:                 readData = mscratch;
      ADDR_MEPC:                     readData = mepc;
      ADDR_MCAUSE:                   readData = mcause;
      ADDR_MTVAL:                    readData = mtval;
      ADDR_MCYCLE,   ADDR_CYCLE:     readData = mcycle[31:0];
      ADDR_MCYCLEH,  ADDR_CYCLEH:    readData = mcycle[63:32];
      ADDR_MINSTRET, ADDR_INSTRET:   readData = minstret[31:0];
      ADDR_MINSTRETH, ADDR_INSTRETH: readData = minstret[63:32];
      default:                       readData = '0;
    endcase
  end

  assign readIllegal = readEnable & (~readMapped | (readAddr[9:8] > privilege));
  assign readValue   = (readEnable & ~readIllegal) ? readData : 32'h0;

  // ---------------------------------------------------------------------------
  // Action arbitration: trap beats mret beats CSR write
  // ---------------------------------------------------------------------------
  logic doTrap;
  logic doMret;
  logic writeLegal;
  logic doWrite;

  assign doTrap     = trapValid;
  assign doMret     = trapReturn & ~trapValid;
  assign writeLegal = csrMapped(writeAddr) && (writeAddr[11:10] != 2'b11)
                      && (writeAddr[9:8] <= privilege);
  assign doWrite    = writeEnable & writeLegal & ~trapValid & ~trapReturn;

  logic wrMstatus, wrMtvec, wrMscratch, wrMepc, wrMcause, wrMtval;
  logic wrMcycleLo, wrMcycleHi, wrMinstretLo, wrMinstretHi;

  assign wrMstatus    = doWrite && (writeAddr == ADDR_MSTATUS);
  assign wrMtvec      = doWrite && (writeAddr == ADDR_MTVEC);
  assign wrMscratch   = doWrite && (writeAddr == ADDR_MSCRATCH);
  assign wrMepc       = doWrite && (writeAddr == ADDR_MEPC);
  assign wrMcause     = doWrite && (writeAddr == ADDR_MCAUSE);
  assign wrMtval      = doWrite && (writeAddr == ADDR_MTVAL);
  assign wrMcycleLo   = doWrite && (writeAddr == ADDR_MCYCLE);
  assign wrMcycleHi   = doWrite && (writeAddr == ADDR_MCYCLEH);
  assign wrMinstretLo = doWrite && (writeAddr == ADDR_MINSTRET);
  assign wrMinstretHi = doWrite && (writeAddr == ADDR_MINSTRETH);

  // ---------------------------------------------------------------------------
  // Privilege and mstatus fields
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstN) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rstN) begin
      privReg <= PRIV_M;
      mpp     <= PRIV_U;
      mie     <= 1'b0;
      mpie    <= 1'b0;
    end else if (doTrap) begin
      mpie    <= mie;
      mie     <= 1'b0;
      mpp     <= privReg;
      privReg <= PRIV_M;
    end else if (doMret) begin
      privReg <= mpp;
      mie     <= mpie;
      mpie    <= 1'b1;
      mpp     <= PRIV_U;
    end else if (wrMstatus) begin
      mie  <= writeValue[3];
      mpie <= writeValue[7];
      // Only U and M exist; an S or reserved encoding leaves MPP untouched.
      if (writeValue[12:11] == 2'b00 || writeValue[12:11] == 2'b11) begin
        mpp <= privT'(writeValue[12:11]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Trap CSRs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mtvec    <= {MTVEC_RESET[31:2], 2'b00};
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
      mtval    <= '0;
    end else if (doTrap) begin
      mepc   <= {trapPc[31:2], 2'b00};
      mcause <= {trapInterrupt, 26'b0, trapCause};
      mtval  <= trapValue;
    end else begin
      if (wrMtvec)    mtvec    <= {writeValue[31:2], 2'b00};
      if (wrMscratch) mscratch <= writeValue;
      if (wrMepc)     mepc     <= {writeValue[31:2], 2'b00};
      if (wrMcause)   mcause   <= writeValue;
      if (wrMtval)    mtval    <= writeValue;
    end
  end

  // ---------------------------------------------------------------------------
  // Redirect: a single-cycle pulse; the target holds between pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      nextPc      <= '0;
      nextPcValid <= 1'b0;
    end else begin
      nextPcValid <= doTrap | doMret;
      if (doTrap) begin
        nextPc <= mtvec;
      end else if (doMret) begin
        nextPc <= mepc;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Counters: a write to either half replaces that cycle's increment
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mcycle <= '0;
    end else if (wrMcycleLo) begin
      mcycle[31:0] <= writeValue;
    end else if (wrMcycleHi) begin
      mcycle[63:32] <= writeValue;
    end else begin
      mcycle <= mcycle + COUNTER_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      minstret <= '0;
    end else if (wrMinstretLo) begin
      minstret[31:0] <= writeValue;
    end else if (wrMinstretHi) begin
      minstret[63:32] <= writeValue;
    end else begin
      minstret <= minstret + COUNTER_WIDTH'(retire);
    end
  end

endmodule

// File: tb/tb_csr_machine_file.sv
// Self-checking bench for csr_machine_file: directed scenarios followed by random traffic,
// all compared against a behavioural model built on address-keyed storage and 64-bit integers.
module tb_csr_machine_file;

  logic        clk = 1'b0;
  logic        rstN;
  logic        readEnable;
  logic [11:0] readAddr;
  logic [31:0] readValue;
  logic        readIllegal;
  logic        writeEnable;
  logic [11:0] writeAddr;
  logic [31:0] writeValue;
  logic        trapValid;
  logic        trapInterrupt;
  logic [4:0]  trapCause;
  logic [31:0] trapValue;
  logic [31:0] trapPc;
  logic        trapReturn;
  logic        retire;
  logic [31:0] nextPc;
  logic        nextPcValid;
  logic [1:0]  privilege;
  logic [31:0] mstatus;

  int compared   = 0;
  int mismatched = 0;

  csr_machine_file #(
    .MTVEC_RESET  (32'h0000_0000),
    .COUNTER_WIDTH(64)
  ) dut (
    .clk          (clk),
    .rstN         (rstN),
    .readEnable   (readEnable),
    .readAddr     (readAddr),
    .readValue    (readValue),
    .readIllegal  (readIllegal),
    .writeEnable  (writeEnable),
    .writeAddr    (writeAddr),
    .writeValue   (writeValue),
    .trapValid    (trapValid),
    .trapInterrupt(trapInterrupt),
    .trapCause    (trapCause),
    .trapValue    (trapValue),
    .trapPc       (trapPc),
    .trapReturn   (trapReturn),
    .retire       (retire),
    .nextPc       (nextPc),
    .nextPcValid  (nextPcValid),
    .privilege    (privilege),
    .mstatus      (mstatus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int              mPriv, mMie, mMpie, mMpp;
  logic [31:0]     mCsr [int];
  longint unsigned mCycle, mInstret;
  logic [31:0]     mNextPc;
  bit              mNextPcValid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    mPriv = 3; mMie = 0; mMpie = 0; mMpp = 0;
    mCsr['h305] = 32'h0; mCsr['h340] = 32'h0; mCsr['h341] = 32'h0;
    mCsr['h342] = 32'h0; mCsr['h343] = 32'h0;
    mCycle = 0; mInstret = 0;
    mNextPc = 32'h0; mNextPcValid = 0;
  endtask

  function automatic bit modelMapped(input int a);
    return a inside {'h300, 'h305, 'h340, 'h341, 'h342, 'h343,
                     'hB00, 'hB80, 'hB02, 'hB82, 'hC00, 'hC80, 'hC02, 'hC82};
  endfunction

  function automatic logic [31:0] modelCsr(input int a);
    case (a)
      'h300:        return 32'((mMie << 3) | (mMpie << 7) | (mMpp << 11));
      'hB00, 'hC00: return mCycle[31:0];
      'hB80, 'hC80: return mCycle[63:32];
      'hB02, 'hC02: return mInstret[31:0];
      'hB82, 'hC82: return mInstret[63:32];
      default:      return mCsr.exists(a) ? mCsr[a] : 32'h0;
    endcase
  endfunction

  task automatic modelEdge();
    int              wa = int'(writeAddr);
    bit              takeTrap = trapValid;
    bit              takeRet = trapReturn && !trapValid;
    bit              takeWrite = writeEnable && !trapValid && !trapReturn && modelMapped(wa)
                                 && ((wa >> 10) != 3) && (((wa >> 8) & 3) <= mPriv);
    longint unsigned nc = mCycle + 1;
    longint unsigned ni = mInstret + (retire ? 1 : 0);
    mNextPcValid = takeTrap || takeRet;
    if (takeTrap) begin
      mNextPc     = mCsr['h305];
      mCsr['h341] = trapPc & 32'hFFFF_FFFC;
      mCsr['h342] = (trapInterrupt ? 32'h8000_0000 : 32'h0) | 32'(trapCause);
      mCsr['h343] = trapValue;
      mMpie = mMie; mMie = 0; mMpp = mPriv; mPriv = 3;
    end else if (takeRet) begin
      mNextPc = mCsr['h341];
      mPriv = mMpp; mMie = mMpie; mMpie = 1; mMpp = 0;
    end
    if (takeWrite) begin
      case (wa)
        'h300: begin
          mMie  = int'(writeValue[3]);
          mMpie = int'(writeValue[7]);
          if (writeValue[12:11] == 2'b00 || writeValue[12:11] == 2'b11) mMpp = int'(writeValue[12:11]);
        end
        'h305, 'h341:        mCsr[wa] = writeValue & 32'hFFFF_FFFC;
        'h340, 'h342, 'h343: mCsr[wa] = writeValue;
        'hB00: nc = (mCycle & 64'hFFFF_FFFF_0000_0000) | 64'(writeValue);
        'hB80: nc = (mCycle & 64'h0000_0000_FFFF_FFFF) | (64'(writeValue) << 32);
        'hB02: ni = (mInstret & 64'hFFFF_FFFF_0000_0000) | 64'(writeValue);
        'hB82: ni = (mInstret & 64'h0000_0000_FFFF_FFFF) | (64'(writeValue) << 32);
        default: ;
      endcase
    end
    mCycle   = nc;
    mInstret = ni;
  endtask

  task automatic checkRead();
    int ra  = int'(readAddr);
    bit ill = readEnable && (!modelMapped(ra) || (((ra >> 8) & 3) > mPriv));
    check("readIllegal", {31'b0, readIllegal}, {31'b0, ill});
    check("readValue", readValue, (readEnable && !ill) ? modelCsr(ra) : 32'h0);
  endtask

  task automatic checkRegs();
    check("privilege", {30'b0, privilege}, 32'(mPriv));
    check("mstatus", mstatus, modelCsr('h300));
    check("nextPcValid", {31'b0, nextPcValid}, {31'b0, mNextPcValid});
    check("nextPc", nextPc, mNextPc);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers (called at posedge+1)
  // ---------------------------------------------------------------------------
  task automatic idle();
    readEnable = 0; readAddr = '0; writeEnable = 0; writeAddr = '0; writeValue = '0;
    trapValid = 0; trapInterrupt = 0; trapCause = '0; trapValue = '0; trapPc = '0;
    trapReturn = 0; retire = 0;
  endtask

  task automatic cycle();
    #1 checkRead();
    @(posedge clk);
    if (rstN) modelEdge();
    #1 checkRegs();
  endtask

  task automatic csrWrite(input logic [11:0] a, input logic [31:0] v);
    idle(); writeEnable = 1; writeAddr = a; writeValue = v;
    cycle();
  endtask

  task automatic peek(input string tag, input logic [11:0] a, input logic [31:0] exp);
    idle(); readEnable = 1; readAddr = a;
    #1 check(tag, readValue, exp);
    cycle();
  endtask

  function automatic logic [11:0] pickAddr();
    logic [11:0] addrs [16] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                                12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80,
                                12'hC02, 12'hC82, 12'h301, 12'h344};
    if ($urandom_range(0, 16) == 16) return 12'($urandom());
    return addrs[$urandom_range(0, 15)];
  endfunction

  initial begin
    idle();
    rstN = 0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_priv", {30'b0, privilege}, 32'd3);
    check("rst_mstatus", mstatus, 32'h0);
    check("rst_pcValid", {31'b0, nextPcValid}, 32'd0);
    rstN = 1;

    // Four idle cycles out of reset: mcycle reads 3 in the fourth
    for (int i = 0; i < 4; i++) begin
      idle(); readEnable = 1; readAddr = 12'hB00;
      if (i == 3) begin
        #1 check("t1_mcycle", readValue, 32'd3);
      end
      cycle();
    end
    check("t1_priv", {30'b0, privilege}, 32'd3);

    // Trap entry with an unaligned mtvec and trap PC
    csrWrite(12'h305, 32'h8000_0103);
    idle(); trapValid = 1; trapCause = 5'd2; trapPc = 32'h8000_0046; trapValue = 32'hDEAD;
    cycle();
    check("t2_pcValid", {31'b0, nextPcValid}, 32'd1);
    check("t2_nextPc", nextPc, 32'h8000_0100);
    check("t2_mstatus", mstatus, 32'h0000_1800);
    peek("t2_mepc", 12'h341, 32'h8000_0044);
    check("t2_pulseEnd", {31'b0, nextPcValid}, 32'd0);
    peek("t2_mcause", 12'h342, 32'h0000_0002);
    peek("t2_mtval", 12'h343, 32'h0000_DEAD);

    // mret into U, then an M-only read from U
    csrWrite(12'h300, 32'h0000_0088);
    csrWrite(12'h341, 32'h0000_0200);
    idle(); trapReturn = 1;
    cycle();
    check("t3_pcValid", {31'b0, nextPcValid}, 32'd1);
    check("t3_nextPc", nextPc, 32'h0000_0200);
    check("t3_priv", {30'b0, privilege}, 32'd0);
    check("t3_mstatus", mstatus, 32'h0000_0088);
    idle(); readEnable = 1; readAddr = 12'h300;
    #1;
    check("t3_illegal", {31'b0, readIllegal}, 32'd1);
    check("t3_value", readValue, 32'h0);
    cycle();
    csrWrite(12'h340, 32'h0000_1234);
    idle(); readEnable = 1; readAddr = 12'hC00;
    #1 check("t3_userCycleLegal", {31'b0, readIllegal}, 32'd0);
    cycle();

    // Trap, mret and write together: only the trap happens
    idle(); trapValid = 1; trapReturn = 1; writeEnable = 1; writeAddr = 12'h340;
    writeValue = 32'h55; trapCause = 5'd3; trapPc = 32'h0000_0300;
    cycle();
    check("t4_nextPc", nextPc, 32'h8000_0100);
    check("t4_priv", {30'b0, privilege}, 32'd3);
    check("t4_mstatus", mstatus, 32'h0000_0080);
    peek("t4_mscratch", 12'h340, 32'h0);

    // MPP encodings 1/2 are not accepted
    csrWrite(12'h300, 32'h0000_1000);
    check("mpp_keep", mstatus, 32'h0000_0000);
    csrWrite(12'h300, 32'h0000_1808);
    check("mpp_set", mstatus, 32'h0000_1808);

    // Counter wrap and read-only shadow
    csrWrite(12'hB00, 32'hFFFF_FFFF);
    csrWrite(12'hB80, 32'hFFFF_FFFF);
    peek("t5_allOnes", 12'hB80, 32'hFFFF_FFFF);
    peek("t5_wrap", 12'hB80, 32'h0);
    csrWrite(12'hC00, 32'h0000_1234);
    peek("t5_readOnly", 12'hC00, 32'd2);

    // minstret: write beats retire, trap does not block retire
    idle(); writeEnable = 1; writeAddr = 12'hB02; writeValue = 32'd5; retire = 1;
    cycle();
    idle(); trapValid = 1; retire = 1; trapPc = 32'h0000_0010;
    cycle();
    peek("t5_instret", 12'hB02, 32'd6);

    // Reset in the cycle after a trap
    idle(); trapValid = 1; trapPc = 32'h0000_1234; trapCause = 5'd7;
    cycle();
    check("t6_preReset", {31'b0, nextPcValid}, 32'd1);
    rstN = 0;
    modelReset();
    idle(); readEnable = 1; readAddr = 12'h341;
    #1;
    check("t6_pcValid", {31'b0, nextPcValid}, 32'd0);
    check("t6_priv", {30'b0, privilege}, 32'd3);
    check("t6_mstatus", mstatus, 32'h0);
    check("t6_mepc", readValue, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("t6_heldLow", {31'b0, nextPcValid}, 32'd0);
    rstN = 1;

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      idle();
      readEnable    = ($urandom_range(0, 3) != 0);
      readAddr      = pickAddr();
      writeEnable   = 1'($urandom_range(0, 1));
      writeAddr     = pickAddr();
      writeValue    = $urandom();
      trapValid     = ($urandom_range(0, 15) == 0);
      trapInterrupt = 1'($urandom_range(0, 1));
      trapCause     = 5'($urandom());
      trapValue     = $urandom();
      trapPc        = $urandom();
      trapReturn    = ($urandom_range(0, 9) == 0);
      retire        = 1'($urandom_range(0, 1));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
